// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared owner encoding and response-tag type for mem_arbiter
package mem_arbiter_pkg;

    // Which port owns a memory access.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Tag for the single outstanding read: valid plus owner.
    typedef struct packed {
        logic valid;
        logic owner;
    } rsp_tag_t;

    localparam int RSP_TAG_W = $bits(rsp_tag_t);

    localparam rsp_tag_t RSP_TAG_IDLE = '{valid: 1'b0, owner: OWN_IF};

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-input selector, fixed data priority or round-robin under MEM_ARB_RR_EN
import mem_arbiter_pkg::*;

module mem_arb_pick (
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic if_pick,
    output logic d_pick
);

`ifdef MEM_ARB_RR_EN
    // Round-robin: on contention the port that did not win last time goes first.
    always_comb begin
        if_pick = 1'b0;
        d_pick  = 1'b0;
        if (if_req && d_req) begin
            if (last_owner == OWN_IF) begin
                d_pick = 1'b1;
            end else begin
                if_pick = 1'b1;
            end
        end else begin
            if_pick = if_req;
            d_pick  = d_req;
        end
    end
`else
    // Fixed priority: the data port always wins, fetch waits.
    always_comb begin
        if_pick = 1'b0;
        d_pick  = 1'b0;
        if (d_req) begin
            d_pick = 1'b1;
        end else if (if_req) begin
            if_pick = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a unified synchronous-read memory; MEM_ARB_RR_EN selects round-robin
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    logic     if_pick;
    logic     d_pick;
    logic     rd_grant;
    rsp_tag_t rsp_tag;

`ifdef MEM_ARB_RR_EN
    logic last_owner;
`endif

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .if_pick    (if_pick),
        .d_pick     (d_pick)
    );

    // Grants are held off while reset is asserted so the memory sees no access.
    assign if_gnt = if_pick & reset;
    assign d_gnt  = d_pick  & reset;

    // Route the granted port onto the memory bus; idle bus is all zeros.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        if (d_gnt) begin
            mem_addr = d_addr;
            mem_we   = d_we;
            mem_wd   = d_wdata;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    // A granted read (fetch, or data with we low) produces a response next cycle.
    assign rd_grant = if_gnt | (d_gnt & ~d_we);

    // Response tag: records who owns the read issued this cycle; lives one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_tag <= RSP_TAG_IDLE;
        end else begin
            rsp_tag.valid <= rd_grant;
            rsp_tag.owner <= d_gnt ? OWN_D : OWN_IF;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Last-owner register: updated on every grant, read or write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_IF;
        end else if (d_gnt) begin
            last_owner <= OWN_D;
        end else if (if_gnt) begin
            last_owner <= OWN_IF;
        end
    end
`endif

    // Steer the memory read data to the tag owner; the other port sees zero.
    assign if_rvalid = rsp_tag.valid & (rsp_tag.owner == OWN_IF);
    assign d_rvalid  = rsp_tag.valid & (rsp_tag.owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rd : '0;
    assign d_rdata   = d_rvalid  ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total;
    int bad;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model, read-before-write.
    always @(posedge clk) begin
        mem_rd <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [1:0] exp_gnt [0:2];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        mem[16'h0010] = 16'hABCD;
        mem_rd = '0;

        // Reset state with both requests high: everything forced quiet.
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0010;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'h5555;
        tick();
        settle();
        check("rst_if_gnt",   {31'd0, if_gnt},    32'd0);
        check("rst_d_gnt",    {31'd0, d_gnt},     32'd0);
        check("rst_mem_we",   {31'd0, mem_we},    32'd0);
        check("rst_mem_addr", {16'd0, mem_addr},  32'd0);
        check("rst_mem_wd",   {16'd0, mem_wd},    32'd0);
        check("rst_if_rv",    {31'd0, if_rvalid}, 32'd0);
        check("rst_d_rv",     {31'd0, d_rvalid},  32'd0);
        idle_inputs();
        tick();
        reset = 1'b1;

        // Fetch-only read.
        tick();
        if_req  = 1'b1;
        if_addr = 16'h0010;
        settle();
        check("f_if_gnt",   {31'd0, if_gnt},   32'd1);
        check("f_d_gnt",    {31'd0, d_gnt},    32'd0);
        check("f_mem_addr", {16'd0, mem_addr}, 32'h0010);
        check("f_mem_we",   {31'd0, mem_we},   32'd0);
        tick();
        idle_inputs();
        settle();
        check("f_if_rv",    {31'd0, if_rvalid}, 32'd1);
        check("f_if_rdata", {16'd0, if_rdata},  32'hABCD);
        check("f_d_rv",     {31'd0, d_rvalid},  32'd0);
        check("f_d_rdata",  {16'd0, d_rdata},   32'd0);
        check("f_idle_addr",{16'd0, mem_addr},  32'd0);
        tick();
        settle();
        check("f_if_rv_once", {31'd0, if_rvalid}, 32'd0);

        // Data write then read of the same address.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'h1234;
        settle();
        check("w_d_gnt",    {31'd0, d_gnt},    32'd1);
        check("w_mem_we",   {31'd0, mem_we},   32'd1);
        check("w_mem_addr", {16'd0, mem_addr}, 32'h0200);
        check("w_mem_wd",   {16'd0, mem_wd},   32'h1234);
        tick();
        d_we    = 1'b0;
        d_wdata = '0;
        settle();
        check("w_no_rv",    {31'd0, d_rvalid}, 32'd0);
        check("r_d_gnt",    {31'd0, d_gnt},    32'd1);
        check("r_mem_we",   {31'd0, mem_we},   32'd0);
        tick();
        idle_inputs();
        settle();
        check("r_d_rv",     {31'd0, d_rvalid},  32'd1);
        check("r_d_rdata",  {16'd0, d_rdata},   32'h1234);
        check("r_if_rv",    {31'd0, if_rvalid}, 32'd0);
        check("r_if_rdata", {16'd0, if_rdata},  32'd0);

        // Contention straight after reset: first edge after release grants.
`ifdef MEM_ARB_RR_EN
        exp_gnt[0] = 2'b01;
        exp_gnt[1] = 2'b10;
        exp_gnt[2] = 2'b01;
`else
        exp_gnt[0] = 2'b01;
        exp_gnt[1] = 2'b01;
        exp_gnt[2] = 2'b01;
`endif
        do_reset();
        if_req  = 1'b1;
        if_addr = 16'h0010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0200;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("arb_gnt_%0d", c), {30'd0, if_gnt, d_gnt}, {30'd0, exp_gnt[c]});
            check($sformatf("arb_rv_excl_%0d", c), {31'd0, if_rvalid & d_rvalid}, 32'd0);
            tick();
        end
        idle_inputs();
        tick();

        // Pipelined: fetch read then data read in consecutive cycles.
        if_req  = 1'b1;
        if_addr = 16'h0010;
        settle();
        check("p_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        if_req = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0200;
        settle();
        check("p_d_gnt",     {31'd0, d_gnt},     32'd1);
        check("p1_if_rv",    {31'd0, if_rvalid}, 32'd1);
        check("p1_if_rdata", {16'd0, if_rdata},  32'hABCD);
        check("p1_d_rv",     {31'd0, d_rvalid},  32'd0);
        tick();
        idle_inputs();
        settle();
        check("p2_d_rv",     {31'd0, d_rvalid},  32'd1);
        check("p2_d_rdata",  {16'd0, d_rdata},   32'h1234);
        check("p2_if_rv",    {31'd0, if_rvalid}, 32'd0);
        tick();

        // Request withdrawn before the edge leaves no response behind.
        d_req  = 1'b1;
        d_addr = 16'h0200;
        settle();
        check("drop_gnt_seen", {31'd0, d_gnt}, 32'd1);
        d_req = 1'b0;
        settle();
        check("drop_gnt_gone", {31'd0, d_gnt}, 32'd0);
        tick();
        settle();
        check("drop_no_rv", {31'd0, d_rvalid}, 32'd0);

        // Reset in the middle of a granted data read.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0200;
        settle();
        check("mr_d_gnt", {31'd0, d_gnt}, 32'd1);
        reset = 1'b0;
        settle();
        check("mr_rst_d_gnt",    {31'd0, d_gnt},    32'd0);
        check("mr_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        tick();
        settle();
        check("mr_rst_d_rv",     {31'd0, d_rvalid}, 32'd0);
        check("mr_rst_d_rdata",  {16'd0, d_rdata},  32'd0);
        idle_inputs();
        reset = 1'b1;
        tick();
        settle();
        check("mr_post_d_rv1", {31'd0, d_rvalid}, 32'd0);
        tick();
        settle();
        check("mr_post_d_rv2", {31'd0, d_rvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
